game_ctrl: RTL and testbench

Round sequencer for the reaction-game datapath (RNG → LED timer → switch scorer → score display). It runs the game from idle through a countdown, a timed play phase and game over, and latches the difficulty level for the whole round. It gates RNG LED requests so LEDs only light during play, clears score and LEDs at round boundaries, and keeps a session high score.

---
 rtl/game_ctrl.sv | 148 ++++++++++++++
 tb/tb_game_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : game_ctrl
// Brief   : Round sequencer for the reaction game: IDLE -> COUNTDOWN -> PLAY
//           -> OVER, with per-second prescaler, LED request gating and a
//           session high score.
// Revision: 1.0 - initial release
// ============================================================================
module game_ctrl #(
    parameter int TICKS_PER_SEC     = 50_000_000,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int GAME_SECONDS      = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] level_in,
    input  logic       rng_request_in,
    input  logic [7:0] score_in,
    output logic [1:0] level_out,
    output logic       led_request_out,
    output logic       run,
    output logic       score_clear,
    output logic       led_clear,
    output logic [5:0] time_left,
    output logic [1:0] state,
    output logic       game_over,
    output logic [7:0] high_score
);

    localparam int              c_CNT_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_CNT_W-1:0] c_TICK_MAX = c_CNT_W'(TICKS_PER_SEC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [5:0]      c_CD_SECS   = 6'(COUNTDOWN_SECONDS);
    localparam logic [5:0]      c_GAME_SECS = 6'(GAME_SECONDS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_COUNTDOWN = 2'b01,
        ST_PLAY      = 2'b10,
        ST_OVER      = 2'b11
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_sec_cnt;
    logic [5:0]           r_time_left;
    logic [1:0]           r_level;
    logic [7:0]           r_high;
    logic                 r_run;
    logic                 r_game_over;
    logic                 r_score_clear;
    logic                 r_led_clear;
    logic                 w_tick;
    logic                 w_last_sec;

    assign w_tick     = (r_sec_cnt == c_TICK_MAX);
    assign w_last_sec = (r_time_left == 6'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_sec_cnt     <= '0;
            r_time_left   <= '0;
            r_level       <= '0;
            r_high        <= '0;
            r_run         <= 1'b0;
            r_game_over   <= 1'b0;
            r_score_clear <= 1'b0;
            r_led_clear   <= 1'b0;
        end else begin
            r_score_clear <= 1'b0;
            r_led_clear   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    r_sec_cnt <= '0;
                    if (start && !abort) begin
                        r_state       <= ST_COUNTDOWN;
                        r_level       <= level_in;
                        r_time_left   <= c_CD_SECS;
                        r_score_clear <= 1'b1;
                        r_game_over   <= 1'b0;
                    end
                end
                ST_COUNTDOWN: begin
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        r_time_left <= '0;
                        r_sec_cnt   <= '0;
                        r_led_clear <= 1'b1;
                    end else if (w_tick) begin
                        r_sec_cnt <= '0;
                        if (w_last_sec) begin
                            r_state     <= ST_PLAY;
                            r_time_left <= c_GAME_SECS;
                            r_run       <= 1'b1;
                        end else begin
                            r_time_left <= r_time_left - 6'd1;
                        end
                    end else begin
                        r_sec_cnt <= r_sec_cnt + c_CNT_ONE;
                    end
                end
                ST_PLAY: begin
                    // abort takes priority over the final tick, so an aborted
                    // round never contributes to the high score
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        r_time_left <= '0;
                        r_sec_cnt   <= '0;
                        r_run       <= 1'b0;
                        r_led_clear <= 1'b1;
                    end else if (w_tick) begin
                        r_sec_cnt <= '0;
                        if (w_last_sec) begin
                            r_state     <= ST_OVER;
                            r_time_left <= '0;
                            r_run       <= 1'b0;
                            r_game_over <= 1'b1;
                            r_led_clear <= 1'b1;
                            if (score_in > r_high) begin
                                r_high <= score_in;
                            end
                        end else begin
                            r_time_left <= r_time_left - 6'd1;
                        end
                    end else begin
                        r_sec_cnt <= r_sec_cnt + c_CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Requests outside PLAY are dropped, not queued
    assign led_request_out = rng_request_in & r_run;
    assign level_out       = r_level;
    assign run             = r_run;
    assign score_clear     = r_score_clear;
    assign led_clear       = r_led_clear;
    assign time_left       = r_time_left;
    assign state           = r_state;
    assign game_over       = r_game_over;
    assign high_score      = r_high;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_game_ctrl
// Brief   : Scoreboard bench for game_ctrl against a phase/elapsed-time model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    localparam int TPS = 4;
    localparam int CDS = 3;
    localparam int GS  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] level_in = 2'd0;
    logic       rng_request_in = 1'b0;
    logic [7:0] score_in = 8'd0;
    logic [1:0] level_out;
    logic       led_request_out;
    logic       run;
    logic       score_clear;
    logic       led_clear;
    logic [5:0] time_left;
    logic [1:0] state;
    logic       game_over;
    logic [7:0] high_score;

    game_ctrl #(
        .TICKS_PER_SEC    (TPS),
        .COUNTDOWN_SECONDS(CDS),
        .GAME_SECONDS     (GS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .level_in       (level_in),
        .rng_request_in (rng_request_in),
        .score_in       (score_in),
        .level_out      (level_out),
        .led_request_out(led_request_out),
        .run            (run),
        .score_clear    (score_clear),
        .led_clear      (led_clear),
        .time_left      (time_left),
        .state          (state),
        .game_over      (game_over),
        .high_score     (high_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int tl;
        int lvl;
        int hs;
        int sclr;
        int lclr;
        int ledreq;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: phase 0..3 plus cycles elapsed inside the phase
    int         m_phase = 0;
    int         m_cyc   = 0;
    int         m_level = 0;
    int         m_high  = 0;
    int         m_sclr  = 0;
    int         m_lclr  = 0;

    function automatic int m_time_left();
        if (m_phase == 1) return CDS - m_cyc / TPS;
        if (m_phase == 2) return GS - m_cyc / TPS;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cyc = 0; m_level = 0; m_high = 0; m_sclr = 0; m_lclr = 0;
    endtask

    task automatic model_step(input int s, input int a, input int lv, input int sc);
        m_sclr = 0;
        m_lclr = 0;
        case (m_phase)
            0, 3: if (s != 0 && a == 0) begin
                m_phase = 1; m_cyc = 0; m_level = lv; m_sclr = 1;
            end
            1: if (a != 0) begin
                m_phase = 0; m_cyc = 0; m_lclr = 1;
            end else begin
                m_cyc++;
                if (m_cyc == CDS * TPS) begin m_phase = 2; m_cyc = 0; end
            end
            default: if (a != 0) begin
                m_phase = 0; m_cyc = 0; m_lclr = 1;
            end else begin
                m_cyc++;
                if (m_cyc == GS * TPS) begin
                    m_phase = 3; m_cyc = 0; m_lclr = 1;
                    if (sc > m_high) m_high = sc;
                end
            end
        endcase
    endtask

    // One clock: drive inputs for the next edge, queue what the DUT shows now
    task automatic cycle(input logic s, input logic a, input logic rn,
                         input logic [1:0] lv, input logic [7:0] sc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rn; start = s; abort = a; level_in = lv; score_in = sc;
        rng_request_in = ~rng_request_in;
        if (!rn) model_reset();
        e.st     = m_phase;
        e.tl     = m_time_left();
        e.lvl    = m_level;
        e.hs     = m_high;
        e.sclr   = m_sclr;
        e.lclr   = m_lclr;
        e.ledreq = (m_phase == 2) ? int'(rng_request_in) : 0;
        sb_q.push_back(e);
        if (rn) model_step(int'(s), int'(a), int'(lv), int'(sc));
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("state",       int'(state),           e.st);
                chk("time_left",   int'(time_left),       e.tl);
                chk("level_out",   int'(level_out),       e.lvl);
                chk("high_score",  int'(high_score),      e.hs);
                chk("run",         int'(run),             (e.st == 2) ? 1 : 0);
                chk("game_over",   int'(game_over),       (e.st == 3) ? 1 : 0);
                chk("score_clear", int'(score_clear),     e.sclr);
                chk("led_clear",   int'(led_clear),       e.lclr);
                chk("led_request", int'(led_request_out), e.ledreq);
            end
        end
    end

    task automatic idle_cycles(input int n, input logic [7:0] sc);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 2'd0, sc);
    endtask

    task automatic full_round(input logic [1:0] lv, input logic [7:0] sc);
        cycle(1'b1, 1'b0, 1'b1, lv, sc);
        idle_cycles((CDS + GS) * TPS + 2, sc);
    endtask

    initial begin : stim
        logic s, a;
        // Reset held, then released
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        idle_cycles(2, 8'd0);

        // Full round: level 2 latched, level_in changes to 1 mid-round
        cycle(1'b1, 1'b0, 1'b1, 2'd2, 8'd17);
        for (int i = 1; i < 36; i++) cycle(1'b0, 1'b0, 1'b1, (i < 5) ? 2'd2 : 2'd1, 8'd17);

        // High-score rule: equal, lower, higher
        full_round(2'd3, 8'd17);
        full_round(2'd0, 8'd9);
        full_round(2'd1, 8'd40);

        // Abort in PLAY at time_left=3, then abort in OVER
        cycle(1'b1, 1'b0, 1'b1, 2'd1, 8'd99);
        idle_cycles(CDS * TPS + 2 * TPS + 1, 8'd99);
        cycle(1'b0, 1'b1, 1'b1, 2'd0, 8'd99);
        idle_cycles(2, 8'd0);
        full_round(2'd2, 8'd5);
        cycle(1'b0, 1'b1, 1'b1, 2'd0, 8'd5);
        idle_cycles(2, 8'd5);

        // start together with abort in PLAY
        cycle(1'b1, 1'b0, 1'b1, 2'd3, 8'd0);
        idle_cycles(CDS * TPS + 3, 8'd0);
        cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'd0);
        idle_cycles(2, 8'd0);

        // Abort on the final PLAY tick with a score that would win
        cycle(1'b1, 1'b0, 1'b1, 2'd2, 8'd200);
        idle_cycles((CDS + GS) * TPS - 1, 8'd200);
        cycle(1'b0, 1'b1, 1'b1, 2'd0, 8'd200);
        idle_cycles(3, 8'd200);

        // Randomised play; start suppressed when abort fires
        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 47) == 0);
            s = !a && ($urandom_range(0, 7) == 0);
            cycle(s, a, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end

        // Async reset asserted between edges mid-COUNTDOWN
        cycle(1'b1, 1'b0, 1'b1, 2'd3, 8'd0);
        idle_cycles(5, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        idle_cycles(3, 8'd0);

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
